// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serializes DATA_W-bit words as
// start bit, data LSB first, optional parity, then 1 or 2 stop bits.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-low
//   data_i   word to transmit, latched on accept (valid_i & ready_o)
//   valid_i  data_i valid; must be held until accepted
//   ready_o  block can accept a word (IDLE only)
//   tx_o     serial line, idle high, driven from a flop
//   busy_o   frame in progress
//   done_o   one-cycle pulse after the last stop bit completes
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_nxt;
    logic [TW-1:0]     timer_q, timer_nxt;
    logic [IW-1:0]     idx_q, idx_nxt;
    logic [DATA_W-1:0] shreg_q, shreg_nxt;
    logic              par_q, par_nxt;
    logic              tx_nxt;
    logic              done_nxt;
    logic              bit_end;

    assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_o    <= 1'b1;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            idx_q   <= idx_nxt;
            shreg_q <= shreg_nxt;
            par_q   <= par_nxt;
            tx_o    <= tx_nxt;
            done_o  <= done_nxt;
            busy_o  <= (state_nxt != S_IDLE);
            ready_o <= (state_nxt == S_IDLE);
        end
    end

    // Next-state logic; tx/busy/ready are registered from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q + TW'(1);
        idx_nxt   = idx_q;
        shreg_nxt = shreg_q;
        par_nxt   = par_q;
        done_nxt  = 1'b0;
        tx_nxt    = 1'b1;

        case (state_q)
            S_IDLE: begin
                timer_nxt = '0;
                idx_nxt   = '0;
                if (valid_i) begin
                    state_nxt = S_START;
                    shreg_nxt = data_i;
                    par_nxt   = (^data_i) ^ 1'(PARITY_ODD);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    timer_nxt = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    shreg_nxt = shreg_q >> 1;
                    if (idx_q == IW'(DATA_W - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_nxt = idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    timer_nxt = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
                idx_nxt   = '0;
            end
        endcase

        // Line level for the coming cycle
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shreg_nxt[0];
            S_PARITY: tx_nxt = par_nxt;
            default:  tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame.
// Three instances share clk/rst/data_i: even parity, odd parity, no parity.
module tb_uart_tx_frame;

    localparam int unsigned CPB = 4;
    localparam int unsigned DW  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          valid [3];
    logic          tx    [3];
    logic          ready [3];
    logic          busy  [3];
    logic          done  [3];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    logic exp_q [$];

    typedef struct {
        int          sel;
        logic [DW-1:0] data;
        logic        pbit;
        bit          has_par;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected line levels, one entry per clock cycle of the frame
    task automatic push_frame(input logic [DW-1:0] d, input logic pbit, input bit has_par);
        logic [DW-1:0] w;
        w = d;
        repeat (CPB) exp_q.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++)
            repeat (CPB) exp_q.push_back(w[i]);
        if (has_par)
            repeat (CPB) exp_q.push_back(pbit);
        repeat (CPB) exp_q.push_back(1'b1);
    endtask

    // Called at a negedge with the selected DUT idle. Returns at the negedge
    // of the cycle in which done is expected high.
    task automatic frame(input int sel, input logic [DW-1:0] d, input logic pbit,
                         input bit has_par, input bit keep_valid, input bit poke_mid);
        int   len;
        logic e;
        len = (2 + int'(DW) + (has_par ? 1 : 0)) * int'(CPB);
        data_i     = d;
        valid[sel] = 1'b1;
        check("ready_pre", 32'(ready[sel]), 32'd1);
        @(posedge clk);
        push_frame(d, pbit, has_par);
        #1;
        if (!keep_valid) valid[sel] = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (poke_mid && c == 10) data_i = 7'h3C;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            check($sformatf("tx[%0d] c%0d", sel, c), 32'(tx[sel]), 32'(e));
            check("busy_in_frame", 32'(busy[sel]), 32'd1);
            check("ready_in_frame", 32'(ready[sel]), 32'd0);
            check("done_early", 32'(done[sel]), 32'd0);
        end
        @(negedge clk);
        check("done_pulse", 32'(done[sel]), 32'd1);
        check("ready_at_done", 32'(ready[sel]), 32'd1);
        check("busy_at_done", 32'(busy[sel]), 32'd0);
        check("tx_at_done", 32'(tx[sel]), 32'd1);
        last_done_cyc = cyc;
    endtask

    initial begin
        int d1;
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;

        // {dut, data, expected parity bit, parity present}
        vecs[0] = '{sel: 0, data: 7'h55, pbit: 1'b0, has_par: 1'b1};
        vecs[1] = '{sel: 0, data: 7'h2A, pbit: 1'b1, has_par: 1'b1};
        vecs[2] = '{sel: 1, data: 7'h00, pbit: 1'b1, has_par: 1'b1};
        vecs[3] = '{sel: 1, data: 7'h55, pbit: 1'b1, has_par: 1'b1};
        vecs[4] = '{sel: 2, data: 7'h55, pbit: 1'b0, has_par: 1'b0};
        vecs[5] = '{sel: 2, data: 7'h01, pbit: 1'b0, has_par: 1'b0};

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", 32'(tx[i]), 32'd1);
            check("rst_ready", 32'(ready[i]), 32'd1);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Idle with no valid
        repeat (20) begin
            @(negedge clk);
            check("idle_tx", 32'(tx[0]), 32'd1);
            check("idle_ready", 32'(ready[0]), 32'd1);
            check("idle_busy", 32'(busy[0]), 32'd0);
            check("idle_done", 32'(done[0]), 32'd0);
        end

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].has_par, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Back-to-back with valid held: accepted in the done cycle, so the
        // next done follows 40 frame cycles plus that one IDLE cycle later.
        frame(0, 7'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        d1 = last_done_cyc;
        frame(0, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_done_gap", 32'(last_done_cyc - d1), 32'd41);
        @(negedge clk);

        // data_i changed mid-frame must not alter the serialized word
        frame(0, 7'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // Asynchronous reset during data bit 3
        data_i   = 7'h2A;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx[0]), 32'd1);
        check("async_rst_busy", 32'(busy[0]), 32'd0);
        check("async_rst_ready", 32'(ready[0]), 32'd1);
        check("async_rst_done", 32'(done[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle_tx", 32'(tx[0]), 32'd1);
        frame(0, 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("final_done_low", 32'(done[0]), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
